// File: rtl/ex_alu_pkg.sv
// Shared encodings for the EX-stage ALU controller: ALUctl codes, main-control
// ALUOp values, opcode/funct numbers and the multiply/divide FSM states.
package ex_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_alu_ctrl_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, followed by a single sign-fixup cycle.
module muldiv_core
  import ex_alu_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        div_q;
  logic        neg_lo_q;
  logic        neg_hi_q;
  logic [31:0] acc_q;
  logic [31:0] mq_q;
  logic [31:0] opb_q;

  logic        is_div;
  logic        is_signed;
  logic        div0;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic [31:0] acc_d;
  logic [31:0] mq_d;
  logic [63:0] prod_fix;

  // op_i is funct[1:0]: bit 1 selects divide, bit 0 selects unsigned.
  // A zero divisor loads the raw dividend with no sign flags, so the restoring
  // loop naturally yields quotient all-ones and remainder equal to rs.
  always_comb begin
    is_div    = op_i[1];
    is_signed = ~op_i[0];
    div0      = is_div & (b_i == 32'd0);
    a_neg     = is_signed & a_i[31] & ~div0;
    b_neg     = is_signed & b_i[31];
    a_mag     = a_neg ? (32'd0 - a_i) : a_i;
    b_mag     = b_neg ? (32'd0 - b_i) : b_i;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q, mq_q[31]};
    div_diff  = div_shift[31:0] - opb_q;
    acc_d     = {mul_sum[32:1]};
    mq_d      = {mul_sum[0], mq_q[31:1]};
    if (div_q) begin
      if (div_shift >= {1'b0, opb_q}) begin
        acc_d = div_diff;
        mq_d  = {mq_q[30:0], 1'b1};
      end else begin
        acc_d = div_shift[31:0];
        mq_d  = {mq_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_fix = neg_lo_q ? (64'd0 - {acc_q, mq_q}) : {acc_q, mq_q};
    if (div_q) begin
      lo_o = neg_lo_q ? (32'd0 - mq_q) : mq_q;
      hi_o = neg_hi_q ? (32'd0 - acc_q) : acc_q;
    end else begin
      hi_o = prod_fix[63:32];
      lo_o = prod_fix[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      count_q  <= 5'd0;
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= 32'd0;
      mq_q     <= 32'd0;
      opb_q    <= 32'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q  <= MD_RUN;
            count_q  <= 5'(MD_ITER - 1);
            busy_q   <= 1'b1;
            div_q    <= is_div;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= is_div & a_neg;
            acc_q    <= 32'd0;
            mq_q     <= a_mag;
            opb_q    <= b_mag;
          end
        end
        MD_RUN: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          if (count_q == 5'd0) begin
            state_q <= MD_FIX;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end
        MD_FIX: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = (state_q == MD_FIX);

endmodule

// File: rtl/ex_alu_ctrl.sv
// EX-stage ALU controller: ALUctl/shift decode, HI/LO ownership and the
// HI/LO hazard stall around the iterative multiply/divide engine.
module ex_alu_ctrl
  import ex_alu_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [3:0]  alu_ctl,
  output logic        shift_c,
  output logic [4:0]  shift_v,
  output logic        sel_hilo,
  output logic [31:0] hilo_out,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        rtype;
  logic        is_mf;
  logic        is_mt;
  logic        is_md;
  logic        hilo_grp;
  logic        accept;
  logic        issue;
  logic        md_busy_w;
  logic        md_done;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  always_comb begin
    alu_ctl = ALU_ADD;
    shift_c = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_ctl = ALU_ADD;
          F_SUB, F_SUBU: alu_ctl = ALU_SUB;
          F_AND:         alu_ctl = ALU_AND;
          F_OR:          alu_ctl = ALU_OR;
          F_XOR:         alu_ctl = ALU_XOR;
          F_NOR:         alu_ctl = ALU_NOR;
          F_SLT, F_SLTU: alu_ctl = ALU_SLT;
          F_SLL:  begin alu_ctl = ALU_SLL; shift_c = 1'b1; end
          F_SRL:  begin alu_ctl = ALU_SRL; shift_c = 1'b1; end
          F_SRA:  begin alu_ctl = ALU_SRA; shift_c = 1'b1; end
          F_SLLV:        alu_ctl = ALU_SLL;
          F_SRLV:        alu_ctl = ALU_SRLV;
          F_SRAV:        alu_ctl = ALU_SRA;
          default:       alu_ctl = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        case (opcode)
          OP_ADDI, OP_ADDIU: alu_ctl = ALU_ADD;
          OP_SLTI, OP_SLTIU: alu_ctl = ALU_SLT;
          OP_ANDI:           alu_ctl = ALU_AND;
          OP_ORI:            alu_ctl = ALU_OR;
          OP_XORI:           alu_ctl = ALU_XOR;
          OP_LUI:            alu_ctl = ALU_LUI;
          default:           alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  assign shift_v = shift_c ? shamt : 5'd0;

  always_comb begin
    rtype    = (alu_op == ALUOP_RTYPE);
    is_mf    = rtype & ((funct == F_MFHI) | (funct == F_MFLO));
    is_mt    = rtype & ((funct == F_MTHI) | (funct == F_MTLO));
    is_md    = rtype & (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    hilo_grp = is_mf | is_mt | is_md;
  end

  // Only HI/LO users wait on the engine; everything else flows past it.
  assign stall    = ex_valid & hilo_grp & md_busy_w;
  assign accept   = ex_valid & ~flush & ~stall;
  assign issue    = accept & is_md;
  assign sel_hilo = ex_valid & is_mf;
  assign hilo_out = (funct == F_MFHI) ? hi_q : lo_q;

  muldiv_core #(
    .MD_ITER (MD_ITER)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (issue),
    .op_i    (funct[1:0]),
    .a_i     (rs_val),
    .b_i     (rt_val),
    .busy_o  (md_busy_w),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  // MT writes can never coincide with md_done: they are stalled while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (accept & is_mt) begin
      if (funct == F_MTHI) begin
        hi_q <= rs_val;
      end else begin
        lo_q <= rs_val;
      end
    end
  end

  assign md_busy = md_busy_w;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_ex_alu_ctrl.sv
// Self-checking bench for ex_alu_ctrl: decode sweep, multiply/divide results
// against an arithmetic reference, HI/LO stall timing, flush/MT and reset.
`timescale 1ns/1ps
module tb_ex_alu_ctrl;
  import ex_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        flush;
  logic [1:0]  alu_op;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  alu_ctl;
  logic        shift_c;
  logic [4:0]  shift_v;
  logic        sel_hilo;
  logic [31:0] hilo_out;
  logic        stall;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] md_q[$];
  logic [9:0]  dec_q[$];
  logic [31:0] mt_q[$];

  // {alu_op, code, alu_ctl, shift_c}
  localparam int NDEC = 29;
  localparam logic [12:0] DEC_TBL [NDEC] = '{
    {2'b00, 6'h00, 4'h2, 1'b0}, {2'b01, 6'h00, 4'h6, 1'b0},
    {2'b10, 6'h20, 4'h2, 1'b0}, {2'b10, 6'h21, 4'h2, 1'b0},
    {2'b10, 6'h22, 4'h6, 1'b0}, {2'b10, 6'h23, 4'h6, 1'b0},
    {2'b10, 6'h24, 4'h0, 1'b0}, {2'b10, 6'h25, 4'h1, 1'b0},
    {2'b10, 6'h26, 4'h8, 1'b0}, {2'b10, 6'h27, 4'h3, 1'b0},
    {2'b10, 6'h2A, 4'h7, 1'b0}, {2'b10, 6'h2B, 4'h7, 1'b0},
    {2'b10, 6'h00, 4'h4, 1'b1}, {2'b10, 6'h02, 4'h5, 1'b1},
    {2'b10, 6'h03, 4'hA, 1'b1}, {2'b10, 6'h04, 4'h4, 1'b0},
    {2'b10, 6'h06, 4'h9, 1'b0}, {2'b10, 6'h07, 4'hA, 1'b0},
    {2'b10, 6'h3F, 4'h2, 1'b0}, {2'b10, 6'h10, 4'h2, 1'b0},
    {2'b11, 6'h08, 4'h2, 1'b0}, {2'b11, 6'h09, 4'h2, 1'b0},
    {2'b11, 6'h0A, 4'h7, 1'b0}, {2'b11, 6'h0B, 4'h7, 1'b0},
    {2'b11, 6'h0C, 4'h0, 1'b0}, {2'b11, 6'h0D, 4'h1, 1'b0},
    {2'b11, 6'h0E, 4'h8, 1'b0}, {2'b11, 6'h0F, 4'hF, 1'b0},
    {2'b11, 6'h23, 4'h2, 1'b0}
  };

  always #5 clk = ~clk;

  ex_alu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .flush    (flush),
    .alu_op   (alu_op),
    .opcode   (opcode),
    .funct    (funct),
    .shamt    (shamt),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_ctl  (alu_ctl),
    .shift_c  (shift_c),
    .shift_v  (shift_v),
    .sel_hilo (sel_hilo),
    .hilo_out (hilo_out),
    .stall    (stall),
    .md_busy  (md_busy),
    .hi       (hi),
    .lo       (lo)
  );

  function automatic logic [63:0] model_md(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (fn)
      F_MULT:  r = 64'(sa * sb);
      F_MULTU: r = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin
          r[31:0]  = 32'(sa / sb);
          r[63:32] = 32'(sa % sb);
        end
      end
      F_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin
          r[31:0]  = a / b;
          r[63:32] = a % b;
        end
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic [1:0] aop,
                       input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    ex_valid = v;
    flush    = fl;
    alu_op   = aop;
    opcode   = opc;
    funct    = fn;
    shamt    = sh;
    rs_val   = a;
    rt_val   = b;
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, ALUOP_ADD, 6'h00, 6'h00, 5'd0, 32'd0, 32'd0);
  endtask

  // Presents a multiply/divide for one edge and records the expected HI:LO.
  task automatic issue_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_v);
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, fn, 5'd0, a, b);
    md_q.push_back(exp_v);
    tick();
    idle_bus();
  endtask

  task automatic wait_not_busy(output int cyc);
    cyc = 0;
    while (md_busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_MFHI, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    n_checks++;
    if ({hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL reset_hilo: got %h expected %h", {hi, lo}, 64'd0);
    end
    n_checks++;
    if (md_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", md_busy);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    n_checks++;
    if (sel_hilo !== 1'b1) begin
      n_fail++; $display("FAIL reset_sel_hilo: got %b expected 1", sel_hilo);
    end
    $display("reset: hi=%h lo=%h busy=%b", hi, lo, md_busy);
    reset = 1'b0;
    idle_bus();
    tick();
  endtask

  task automatic test_decode();
    logic [12:0] ent;
    logic [4:0]  sh;
    logic [9:0]  exp_v;
    for (int i = 0; i < NDEC; i++) begin
      ent = DEC_TBL[i];
      sh  = 5'(((i * 7) % 31) + 1);
      if (ent[12:11] == ALUOP_RTYPE)
        drive(1'b1, 1'b0, ent[12:11], 6'h00, ent[10:5], sh, 32'd0, 32'd0);
      else if (ent[12:11] == ALUOP_ITYPE)
        drive(1'b1, 1'b0, ent[12:11], ent[10:5], F_SRA, sh, 32'd0, 32'd0);
      else
        drive(1'b1, 1'b0, ent[12:11], OP_LUI, F_SRA, sh, 32'd0, 32'd0);
      dec_q.push_back({ent[4:1], ent[0], ent[0] ? sh : 5'd0});
      #1;
      exp_v = dec_q.pop_front();
      n_checks++;
      if ({alu_ctl, shift_c, shift_v} !== exp_v) begin
        n_fail++;
        $display("FAIL decode[%0d] aop=%b code=%h: got ctl=%h sc=%b sv=%0d expected ctl=%h sc=%b sv=%0d",
                 i, ent[12:11], ent[10:5], alu_ctl, shift_c, shift_v, exp_v[9:6], exp_v[5], exp_v[4:0]);
      end
      $display("decode aop=%b code=%h shamt=%0d -> ctl=%h sc=%b sv=%0d",
               ent[12:11], ent[10:5], sh, alu_ctl, shift_c, shift_v);
    end
    idle_bus();
    tick();
  endtask

  task automatic test_mult();
    int          cyc;
    logic [63:0] exp_v;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin fn = F_MULT;  a = 32'hFFFFFFFE; b = 32'd3; end
        1: begin fn = F_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
        2: begin fn = F_MULT;  a = 32'h80000000; b = 32'h80000000; end
        default: begin fn = (i % 2 == 1) ? F_MULTU : F_MULT; a = $urandom; b = $urandom; end
      endcase
      if (i == 0)      exp_v = 64'hFFFFFFFF_FFFFFFFA;
      else if (i == 1) exp_v = 64'hFFFFFFFE_00000001;
      else             exp_v = model_md(fn, a, b);
      issue_md(fn, a, b, exp_v);
      wait_not_busy(cyc);
      n_checks++;
      if (cyc != 33) begin
        n_fail++; $display("FAIL mult_busy_cycles[%0d]: got %0d expected 33", i, cyc);
      end
      exp_v = md_q.pop_front();
      n_checks++;
      if ({hi, lo} !== exp_v) begin
        n_fail++; $display("FAIL mult_result[%0d] f=%h a=%h b=%h: got %h expected %h",
                           i, fn, a, b, {hi, lo}, exp_v);
      end
      $display("mult f=%h a=%h b=%h -> hi=%h lo=%h busy=%0d", fn, a, b, hi, lo, cyc);
    end
  endtask

  task automatic test_div();
    int          cyc;
    logic [63:0] exp_v;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin fn = F_DIV;  a = 32'hFFFFFFF9; b = 32'd2; end
        1: begin fn = F_DIV;  a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin fn = F_DIVU; a = 32'h00001234; b = 32'd0; end
        3: begin fn = F_DIV;  a = 32'hFFFFFFFB; b = 32'd0; end
        default: begin
          fn = (i % 2 == 1) ? F_DIVU : F_DIV;
          a  = $urandom;
          b  = 32'($urandom_range(1, 5000));
          if (i == 6) b = 32'd0 - b;
        end
      endcase
      case (i)
        0: exp_v = {32'hFFFFFFFF, 32'hFFFFFFFD};
        1: exp_v = {32'h00000000, 32'h80000000};
        2: exp_v = {32'h00001234, 32'hFFFFFFFF};
        3: exp_v = {32'hFFFFFFFB, 32'hFFFFFFFF};
        default: exp_v = model_md(fn, a, b);
      endcase
      issue_md(fn, a, b, exp_v);
      wait_not_busy(cyc);
      n_checks++;
      if (cyc != 33) begin
        n_fail++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 33", i, cyc);
      end
      exp_v = md_q.pop_front();
      n_checks++;
      if ({hi, lo} !== exp_v) begin
        n_fail++; $display("FAIL div_result[%0d] f=%h a=%h b=%h: got %h expected %h",
                           i, fn, a, b, {hi, lo}, exp_v);
      end
      $display("div f=%h a=%h b=%h -> hi=%h lo=%h busy=%0d", fn, a, b, hi, lo, cyc);
    end
  endtask

  task automatic test_stall();
    int          cyc;
    logic [63:0] exp_v;
    // An ADD right behind a MULT is not held up.
    issue_md(F_MULT, 32'h00001234, 32'h00000010, model_md(F_MULT, 32'h00001234, 32'h00000010));
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_ADD, 5'd0, 32'd1, 32'd2);
    #1;
    n_checks++;
    if (stall !== 1'b0 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL shadow_add: got stall=%b busy=%b expected stall=0 busy=1", stall, md_busy);
    end
    $display("shadow add: stall=%b busy=%b", stall, md_busy);
    idle_bus();
    wait_not_busy(cyc);
    exp_v = md_q.pop_front();
    n_checks++;
    if ({hi, lo} !== exp_v) begin
      n_fail++; $display("FAIL shadow_mult_result: got %h expected %h", {hi, lo}, exp_v);
    end
    // MFLO right behind a MULT waits for the product.
    issue_md(F_MULT, 32'hFFFFFFF0, 32'd5, model_md(F_MULT, 32'hFFFFFFF0, 32'd5));
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_MFLO, 5'd0, 32'd0, 32'd0);
    #1;
    cyc = 0;
    while (stall && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (cyc != 33) begin
      n_fail++; $display("FAIL mflo_stall_cycles: got %0d expected 33", cyc);
    end
    exp_v = md_q.pop_front();
    n_checks++;
    if (sel_hilo !== 1'b1 || hilo_out !== exp_v[31:0]) begin
      n_fail++; $display("FAIL mflo_value: got sel=%b out=%h expected sel=1 out=%h",
                         sel_hilo, hilo_out, exp_v[31:0]);
    end
    $display("mflo after mult: stall_cycles=%0d hilo_out=%h", cyc, hilo_out);
    idle_bus();
    tick();
  endtask

  task automatic test_flush_mt();
    int          cyc;
    logic [63:0] exp_v;
    logic [31:0] exp_w;
    drive(1'b1, 1'b1, ALUOP_RTYPE, 6'h00, F_MULT, 5'd0, 32'd3, 32'd4);
    tick();
    idle_bus();
    tick();
    n_checks++;
    if (md_busy !== 1'b0) begin
      n_fail++; $display("FAIL flushed_mult_busy: got %b expected 0", md_busy);
    end
    $display("flushed mult: busy=%b", md_busy);
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_MTHI, 5'd0, 32'hA5A5A5A5, 32'd0);
    mt_q.push_back(32'hA5A5A5A5);
    tick();
    idle_bus();
    exp_w = mt_q.pop_front();
    n_checks++;
    if (hi !== exp_w) begin
      n_fail++; $display("FAIL mthi: got %h expected %h", hi, exp_w);
    end
    $display("mthi: hi=%h", hi);
    drive(1'b1, 1'b1, ALUOP_RTYPE, 6'h00, F_MTHI, 5'd0, 32'h11111111, 32'd0);
    tick();
    idle_bus();
    n_checks++;
    if (hi !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL flushed_mthi: got %h expected %h", hi, 32'hA5A5A5A5);
    end
    // MTLO held behind a running MULTU.
    issue_md(F_MULTU, 32'd2, 32'd3, 64'h00000000_00000006);
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_MTLO, 5'd0, 32'hDEADBEEF, 32'd0);
    #1;
    cyc = 0;
    while (stall && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (cyc != 33) begin
      n_fail++; $display("FAIL mtlo_stall_cycles: got %0d expected 33", cyc);
    end
    exp_v = md_q.pop_front();
    n_checks++;
    if ({hi, lo} !== exp_v) begin
      n_fail++; $display("FAIL mtlo_mult_result: got %h expected %h", {hi, lo}, exp_v);
    end
    mt_q.push_back(32'hDEADBEEF);
    tick();
    idle_bus();
    exp_w = mt_q.pop_front();
    n_checks++;
    if (lo !== exp_w || hi !== 32'd0) begin
      n_fail++; $display("FAIL mtlo_after_stall: got hi=%h lo=%h expected hi=0 lo=%h", hi, lo, exp_w);
    end
    $display("mtlo after stall: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_reset_mid();
    int          cyc;
    logic [63:0] exp_v;
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_MULT, 5'd0, 32'h55, 32'h66);
    tick();
    drive(1'b1, 1'b0, ALUOP_RTYPE, 6'h00, F_MFHI, 5'd0, 32'd0, 32'd0);
    repeat (10) tick();
    n_checks++;
    if (stall !== 1'b1 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_run: got stall=%b busy=%b expected 1 1", stall, md_busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || {hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b stall=%b hilo=%h expected 0 0 0",
                         md_busy, stall, {hi, lo});
    end
    $display("mid-run reset: busy=%b stall=%b hi=%h lo=%h", md_busy, stall, hi, lo);
    tick();
    reset = 1'b0;
    idle_bus();
    tick();
    exp_v = model_md(F_MULT, 32'hFFFF0000, 32'h00010003);
    issue_md(F_MULT, 32'hFFFF0000, 32'h00010003, exp_v);
    wait_not_busy(cyc);
    n_checks++;
    if (cyc != 33) begin
      n_fail++; $display("FAIL post_reset_busy_cycles: got %0d expected 33", cyc);
    end
    exp_v = md_q.pop_front();
    n_checks++;
    if ({hi, lo} !== exp_v) begin
      n_fail++; $display("FAIL post_reset_mult: got %h expected %h", {hi, lo}, exp_v);
    end
    $display("post-reset mult: hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_bus();
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_stall();
    test_flush_mt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
